// File: rtl/spi_mem_ctrl.sv
// SPI mode-0 master for 25-series EEPROM/flash behind a 4-register bus window.
// Runs READ/WRITE/WREN/RDSR frames on its own and reports completion via busy/done.
module spi_mem_ctrl #(
  parameter int ADDR_BYTES = 3,
  parameter int DATA_BYTES = 4,
  parameter int CLK_DIV    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_wr,
  input  logic        reg_rd,
  input  logic [1:0]  reg_sel,
  input  logic [31:0] reg_din,
  output logic [31:0] reg_dout,
  output logic        busy,
  output logic        done,
  output logic        spi_sck,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_hold_n,
  output logic        spi_wp_n,
  output logic [1:0]  dbg_state
);

  localparam int AW = 8 * ADDR_BYTES;
  localparam int DW = 8 * DATA_BYTES;
  localparam int FW = 8 + AW + DW;
  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [6:0]  N_RW     = 7'(FW);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD} state_t;

  // Bus handshake: reg_wr/reg_rd are single-clk strobes with no ready; a write
  // is taken only while busy=0 (otherwise dropped and flagged in ovr), and
  // reg_dout is valid the clk after reg_rd.
  state_t      state_q, state_d;
  logic [15:0] div_q, div_d;
  logic [6:0]  bit_q, bit_d, nbits_q, nbits_d;
  logic [1:0]  cmd_q, cmd_d;
  logic [63:0] tx_q, tx_d;
  logic [31:0] rx_q, rx_d;
  logic        sck_q, sck_d, cs_n_q, cs_n_d, mosi_q, mosi_d;
  logic        busy_q, busy_d, done_q, done_d, ovr_q, ovr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [7:0]  stat_q, stat_d;
  logic [31:0] dout_q, dout_d;
  logic        unused_bits;

  assign unused_bits = ^{reg_din, rx_q};

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    nbits_d = nbits_q;
    cmd_d   = cmd_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    sck_d   = sck_q;
    cs_n_d  = cs_n_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    stat_d  = stat_q;
    dout_d  = dout_q;

    if (reg_rd) begin
      unique case (reg_sel)
        2'b00: begin
          dout_d = {16'h0, stat_q, 6'h0, ovr_q, busy_q};
          ovr_d  = 1'b0;
        end
        2'b01:   dout_d = 32'(addr_q);
        2'b10:   dout_d = 32'(wdata_q);
        default: dout_d = 32'(rdata_q);
      endcase
    end

    // A dropped write sets ovr after the read-clear so the newer event wins.
    if (reg_wr && reg_sel != 2'b11) begin
      if (busy_q) ovr_d = 1'b1;
      else if (reg_sel == 2'b01) addr_d = reg_din[AW-1:0];
      else if (reg_sel == 2'b10) wdata_d = reg_din[DW-1:0];
    end

    unique case (state_q)
      S_IDLE: begin
        if (reg_wr && reg_sel == 2'b00) begin
          cmd_d = reg_din[1:0];
          tx_d  = '0;
          unique case (reg_din[1:0])
            2'b00: begin tx_d[63 -: FW] = {8'h03, addr_q, {DW{1'b0}}}; nbits_d = N_RW; end
            2'b01: begin tx_d[63 -: FW] = {8'h02, addr_q, wdata_q};    nbits_d = N_RW; end
            2'b10: begin tx_d[63:56] = 8'h06; nbits_d = 7'd8;  end
            default: begin tx_d[63:56] = 8'h05; nbits_d = 7'd16; end
          endcase
          mosi_d  = tx_d[63];
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          div_d   = '0;
          bit_d   = '0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = S_SHIFT;
        end else begin
          div_d = div_q + 16'd1;
        end
      end
      S_SHIFT: begin
        if (div_q != DIV_LAST) begin
          div_d = div_q + 16'd1;
        end else begin
          div_d = '0;
          if (!sck_q) begin
            sck_d = 1'b1;
            rx_d  = {rx_q[30:0], spi_miso};
          end else begin
            // Falling edge: retire the bit and present the next one.
            sck_d  = 1'b0;
            tx_d   = tx_q << 1;
            mosi_d = tx_q[62];
            bit_d  = bit_q + 7'd1;
            if (bit_q == nbits_q - 7'd1) state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = S_IDLE;
          cs_n_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          mosi_d  = 1'b0;
          if (cmd_q == 2'b00) rdata_d = rx_q[DW-1:0];
          if (cmd_q == 2'b11) stat_d  = rx_q[7:0];
        end else begin
          div_d = div_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      nbits_q <= '0;
      cmd_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      sck_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      stat_q  <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      nbits_q <= nbits_d;
      cmd_q   <= cmd_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      sck_q   <= sck_d;
      cs_n_q  <= cs_n_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      stat_q  <= stat_d;
      dout_q  <= dout_d;
    end
  end

  assign reg_dout   = dout_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign spi_sck    = sck_q;
  assign spi_cs_n   = cs_n_q;
  assign spi_mosi   = mosi_q;
  assign spi_hold_n = 1'b1;
  assign spi_wp_n   = 1'b1;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Bench for spi_mem_ctrl: default instance plus a 2-addr/1-data/CLK_DIV=1 instance,
// each with a clk-sampled SPI memory model on its pins.
module tb_spi_mem_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        reg_wr0, reg_rd0, busy0, done0, sck0, cs_n0, mosi0, miso0, hold0, wp0;
  logic [1:0]  reg_sel0, st0;
  logic [31:0] reg_din0, reg_dout0;
  logic        reg_wr1, reg_rd1, busy1, done1, sck1, cs_n1, mosi1, miso1, hold1, wp1;
  logic [1:0]  reg_sel1, st1;
  logic [31:0] reg_din1, reg_dout1;

  spi_mem_ctrl u_dut0 (
    .clk(clk), .rst(rst), .reg_wr(reg_wr0), .reg_rd(reg_rd0), .reg_sel(reg_sel0),
    .reg_din(reg_din0), .reg_dout(reg_dout0), .busy(busy0), .done(done0),
    .spi_sck(sck0), .spi_cs_n(cs_n0), .spi_mosi(mosi0), .spi_miso(miso0),
    .spi_hold_n(hold0), .spi_wp_n(wp0), .dbg_state(st0)
  );

  spi_mem_ctrl #(.ADDR_BYTES(2), .DATA_BYTES(1), .CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .reg_wr(reg_wr1), .reg_rd(reg_rd1), .reg_sel(reg_sel1),
    .reg_din(reg_din1), .reg_dout(reg_dout1), .busy(busy1), .done(done1),
    .spi_sck(sck1), .spi_cs_n(cs_n1), .spi_mosi(mosi1), .spi_miso(miso1),
    .spi_hold_n(hold1), .spi_wp_n(wp1), .dbg_state(st1)
  );

  // ---------------- memory models ----------------
  // frameN is the 64-bit stream the memory returns on MISO, first bit at [63].
  logic [63:0] frame0 = '0, sh0 = '0, mcap0 = '0;
  logic [63:0] frame1 = '0, sh1 = '0, mcap1 = '0;
  logic        prev_cs0 = 1'b1, prev_sck0 = 1'b0, prev_cs1 = 1'b1, prev_sck1 = 1'b0;
  int          rises0 = 0, cslow0 = 0, donecnt0 = 0;
  int          rises1 = 0, cslow1 = 0, donecnt1 = 0;

  assign miso0 = sh0[63];
  assign miso1 = sh1[63];

  always @(negedge clk) begin
    if (prev_cs0 && !cs_n0) begin sh0 = frame0; rises0 = 0; cslow0 = 0; mcap0 = '0; end
    if (!cs_n0) cslow0++;
    if (!prev_sck0 && sck0) begin rises0++; mcap0 = {mcap0[62:0], mosi0}; end
    if (prev_sck0 && !sck0) sh0 = sh0 << 1;
    if (done0) donecnt0++;
    prev_cs0  = cs_n0;
    prev_sck0 = sck0;
  end

  always @(negedge clk) begin
    if (prev_cs1 && !cs_n1) begin sh1 = frame1; rises1 = 0; cslow1 = 0; mcap1 = '0; end
    if (!cs_n1) cslow1++;
    if (!prev_sck1 && sck1) begin rises1++; mcap1 = {mcap1[62:0], mosi1}; end
    if (prev_sck1 && !sck1) sh1 = sh1 << 1;
    if (done1) donecnt1++;
    prev_cs1  = cs_n1;
    prev_sck1 = sck1;
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int tests_run    = 0;
  int tests_failed = 0;

  // ---------------- driver tasks ----------------
  task automatic reg_write(input int inst, input logic [1:0] sel, input logic [31:0] din);
    @(negedge clk);
    if (inst == 0) begin reg_wr0 = 1'b1; reg_sel0 = sel; reg_din0 = din; end
    else begin reg_wr1 = 1'b1; reg_sel1 = sel; reg_din1 = din; end
    @(negedge clk);
    reg_wr0 = 1'b0;
    reg_wr1 = 1'b0;
  endtask

  task automatic reg_read(input int inst, input logic [1:0] sel, output logic [31:0] val);
    @(negedge clk);
    if (inst == 0) begin reg_rd0 = 1'b1; reg_sel0 = sel; end
    else begin reg_rd1 = 1'b1; reg_sel1 = sel; end
    @(negedge clk);
    reg_rd0 = 1'b0;
    reg_rd1 = 1'b0;
    val = (inst == 0) ? reg_dout0 : reg_dout1;
  endtask

  task automatic wait_frame(input int inst, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (((inst == 0) ? busy0 : busy1) == 1'b0) begin ok = 1'b1; break; end
    end
    @(negedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] got, exp;
    tests_run++;
    if ({cs_n0, sck0, mosi0, busy0, done0, st0} !== 7'b1000000) begin
      tests_failed++;
      $display("FAIL reset_pins: got %b expected 1000000", {cs_n0, sck0, mosi0, busy0, done0, st0});
    end
    tests_run++;
    if (reg_dout0 !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_dout: got %h expected 00000000", reg_dout0);
    end
    exp_q.push_back(32'h0);
    reg_read(0, 2'b00, got); exp = exp_q.pop_front(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL reset_status: got %h expected %h", got, exp); end
    exp_q.push_back(32'h0);
    reg_read(0, 2'b11, got); exp = exp_q.pop_front(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL reset_rdata: got %h expected %h", got, exp); end
  endtask

  task automatic test_write();
    logic [31:0] got, exp;
    bit ok;
    int base;
    frame0 = '0;
    reg_write(0, 2'b01, 32'h0000_0123);
    reg_write(0, 2'b10, 32'hDEAD_BEEF);
    base = donecnt0;
    reg_write(0, 2'b00, 32'h1);
    wait_frame(0, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL write_timeout: got busy stuck expected busy low"); end
    tests_run++;
    if (mcap0 !== 64'h0200_0123_DEAD_BEEF) begin
      tests_failed++; $display("FAIL write_mosi: got %h expected 02000123deadbeef", mcap0);
    end
    tests_run++;
    if (rises0 != 64 || cslow0 != 260) begin
      tests_failed++; $display("FAIL write_timing: got rises %0d cs_low %0d expected 64 260", rises0, cslow0);
    end
    tests_run++;
    if (donecnt0 - base != 1) begin
      tests_failed++; $display("FAIL write_done: got %0d pulses expected 1", donecnt0 - base);
    end
    exp_q.push_back(32'h0000_0123);
    reg_read(0, 2'b01, got); exp = exp_q.pop_front(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL addr_readback: got %h expected %h", got, exp); end
  endtask

  task automatic test_wren();
    bit ok;
    int base;
    base = donecnt0;
    reg_write(0, 2'b00, 32'h2);
    wait_frame(0, ok);
    tests_run++;
    if (!ok || mcap0[7:0] !== 8'h06 || rises0 != 8 || cslow0 != 36 || donecnt0 - base != 1) begin
      tests_failed++;
      $display("FAIL wren_frame: got ok %0d mosi %h rises %0d cs_low %0d done %0d expected 1 06 8 36 1",
               ok, mcap0[7:0], rises0, cslow0, donecnt0 - base);
    end
  endtask

  task automatic test_read_overrun();
    logic [31:0] got, exp;
    bit ok;
    frame0 = {32'h0, 32'hCAFE_F00D};
    reg_write(0, 2'b01, 32'h0000_ABCD);
    reg_write(0, 2'b00, 32'h0);
    repeat (10) @(negedge clk);
    reg_write(0, 2'b00, 32'h1);
    reg_write(0, 2'b01, 32'h0011_1111);
    tests_run++;
    if (busy0 !== 1'b1) begin tests_failed++; $display("FAIL read_busy: got %b expected 1", busy0); end
    wait_frame(0, ok);
    tests_run++;
    if (!ok || mcap0 !== 64'h0300_ABCD_0000_0000 || rises0 != 64) begin
      tests_failed++;
      $display("FAIL read_frame: got ok %0d mosi %h rises %0d expected 1 0300abcd00000000 64", ok, mcap0, rises0);
    end
    exp_q.push_back(32'hCAFE_F00D);
    exp_q.push_back(32'h0000_0002);
    exp_q.push_back(32'h0000_0000);
    exp_q.push_back(32'h0000_ABCD);
    reg_read(0, 2'b11, got); exp = exp_q.pop_front(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL read_rdata: got %h expected %h", got, exp); end
    reg_read(0, 2'b00, got); exp = exp_q.pop_front(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL ovr_set: got %h expected %h", got, exp); end
    reg_read(0, 2'b00, got); exp = exp_q.pop_front(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL ovr_clear: got %h expected %h", got, exp); end
    reg_read(0, 2'b01, got); exp = exp_q.pop_front(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL addr_kept: got %h expected %h", got, exp); end
  endtask

  task automatic test_rdsr();
    logic [31:0] got, exp;
    bit ok;
    frame0 = {8'h00, 8'h5A, 48'h0};
    reg_write(0, 2'b00, 32'h3);
    wait_frame(0, ok);
    tests_run++;
    if (!ok || mcap0[15:0] !== 16'h0500 || rises0 != 16 || cslow0 != 68) begin
      tests_failed++;
      $display("FAIL rdsr_frame: got ok %0d mosi %h rises %0d cs_low %0d expected 1 0500 16 68",
               ok, mcap0[15:0], rises0, cslow0);
    end
    exp_q.push_back(32'h0000_5A00);
    exp_q.push_back(32'hCAFE_F00D);
    reg_read(0, 2'b00, got); exp = exp_q.pop_front(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL rdsr_status: got %h expected %h", got, exp); end
    reg_read(0, 2'b11, got); exp = exp_q.pop_front(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL rdsr_rdata_kept: got %h expected %h", got, exp); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got, exp, a, d;
    bit ok;
    int base;
    base = donecnt0;
    reg_write(0, 2'b00, 32'h2);
    wait_frame(0, ok);
    reg_write(0, 2'b00, 32'h2);
    wait_frame(0, ok);
    tests_run++;
    if (!ok || donecnt0 - base != 2 || rises0 != 8) begin
      tests_failed++;
      $display("FAIL b2b_wren: got ok %0d done %0d rises %0d expected 1 2 8", ok, donecnt0 - base, rises0);
    end
    frame0 = '0;
    for (int i = 0; i < 3; i++) begin
      a = $urandom_range(0, 32'h00FF_FFFF);
      d = $urandom;
      reg_write(0, 2'b01, a);
      reg_write(0, 2'b10, d);
      reg_write(0, 2'b00, 32'h1);
      wait_frame(0, ok);
      tests_run++;
      if (!ok || mcap0 !== {8'h02, a[23:0], d}) begin
        tests_failed++;
        $display("FAIL rand_write%0d: got %h expected %h", i, mcap0, {8'h02, a[23:0], d});
      end
    end
    exp_q.push_back(32'h0000_5A00);
    reg_read(0, 2'b00, got); exp = exp_q.pop_front(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL b2b_status: got %h expected %h", got, exp); end
  endtask

  task automatic test_small_config();
    logic [31:0] got, exp;
    bit ok;
    frame1 = {24'h0, 8'h7E, 32'h0};
    reg_write(1, 2'b01, 32'h0000_0042);
    reg_write(1, 2'b00, 32'h0);
    wait_frame(1, ok);
    tests_run++;
    if (!ok || rises1 != 32 || cslow1 != 66 || mcap1[31:0] !== 32'h0300_4200) begin
      tests_failed++;
      $display("FAIL small_frame: got ok %0d rises %0d cs_low %0d mosi %h expected 1 32 66 03004200",
               ok, rises1, cslow1, mcap1[31:0]);
    end
    exp_q.push_back(32'h0000_007E);
    reg_read(1, 2'b11, got); exp = exp_q.pop_front(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL small_rdata: got %h expected %h", got, exp); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] got, exp;
    bit ok;
    int base;
    frame0 = '0;
    reg_write(0, 2'b01, 32'h0000_0123);
    reg_write(0, 2'b10, 32'hDEAD_BEEF);
    reg_write(0, 2'b00, 32'h1);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      if (rises0 >= 20) begin ok = 1'b1; break; end
    end
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL abort_timeout: got rises %0d expected 20", rises0); end
    base = donecnt0;
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if ({cs_n0, sck0, mosi0, busy0, st0} !== 6'b100000) begin
      tests_failed++;
      $display("FAIL abort_pins: got %b expected 100000", {cs_n0, sck0, mosi0, busy0, st0});
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    tests_run++;
    if (donecnt0 != base) begin
      tests_failed++; $display("FAIL abort_no_done: got %0d pulses expected 0", donecnt0 - base);
    end
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    reg_read(0, 2'b11, got); exp = exp_q.pop_front(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL abort_rdata: got %h expected %h", got, exp); end
    reg_read(0, 2'b01, got); exp = exp_q.pop_front(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL abort_addr: got %h expected %h", got, exp); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst = 1'b0;
    reg_wr0 = 1'b0; reg_rd0 = 1'b0; reg_sel0 = 2'b00; reg_din0 = '0;
    reg_wr1 = 1'b0; reg_rd1 = 1'b0; reg_sel1 = 2'b00; reg_din1 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_write();
    test_wren();
    test_read_overrun();
    test_rdsr();
    test_back_to_back();
    test_small_config();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
